mem_bus_sequencer: RTL

// Sits between the Riscv core and one single-ported memory bus. Each instruction is serialised as:

---
 rtl/mem_bus_sequencer_pkg.sv | 32 +++
 rtl/mem_bus_sequencer_bus_timeout_counter.sv | 44 ++++
 rtl/mem_bus_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_sequencer_pkg
// Description : Shared definitions for the memory bus sequencer: the FSM
//               state encoding, the default NOP instruction, the width of the
//               bus timeout counter and a word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_sequencer_pkg;

  // Instruction sequencing states. The width is explicit so the encoding is
  // stable for other blocks that decode it.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_DATA   = 3'd3,
    ST_COMMIT = 3'd4
  } seq_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] c_NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam int unsigned c_TIMEOUT_WIDTH = 16;

  // Bus accesses are whole words; any byte offset is a fault.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_sequencer_bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_counter
// Description : Counts cycles of an outstanding bus request that has not been
//               acknowledged. 'expired' rises in the cycle whose count
//               reaches 'limit', so the owner can abandon the request at the
//               same clock edge.
// Ports       : clk, reset (async, active-high)
//               clear   - zero the count (no request outstanding)
//               enable  - request outstanding and not acknowledged this cycle
//               limit   - number of waiting cycles allowed
//               expired - this cycle is the last allowed waiting cycle
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_count_next;

  // One extra bit so the compare never wraps, even at the top of the range.
  assign w_count_next = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
  assign expired      = enable && (w_count_next >= {1'b0, limit});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_count_next[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_sequencer
// Description : Serialises each core instruction on a single-ported memory
//               bus: fetch, one decode cycle, optional data access, then a
//               one-cycle commit window in which core_stall is low. Bus
//               timeouts and misaligned addresses are absorbed here and
//               replaced by a NOP instruction or zero load data.
// Ports       : clk, reset (async, active-high)
//               core side : instr_addr, data_addr, should_read_mem,
//                           should_write_mem, mem_write_data -> instr,
//                           mem_read_data, core_stall
//               bus side  : bus_req, bus_we, bus_addr, bus_wdata <-
//                           bus_ack, bus_rdata
//               status    : fault_timeout, fault_misalign (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_sequencer
  import mem_bus_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = c_NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  input  logic [31:0] data_addr,
  input  logic        should_read_mem,
  input  logic        should_write_mem,
  input  logic [31:0] mem_write_data,
  output logic [31:0] instr,
  output logic [31:0] mem_read_data,
  output logic        core_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        fault_timeout,
  output logic        fault_misalign
);

  localparam logic [c_TIMEOUT_WIDTH-1:0] c_TIMEOUT_LIMIT = c_TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  seq_state_t  r_state;
  logic [31:0] r_instr;
  logic [31:0] r_mem_read_data;
  logic        r_core_stall;
  logic        r_fault_timeout;
  logic        r_fault_misalign;

  logic        w_in_fetch;
  logic        w_in_data;
  logic        w_in_access;
  logic [31:0] w_access_addr;
  logic        w_misaligned;
  logic        w_req;
  logic        w_is_store;
  logic        w_expired;

  // The bus is driven straight from the state and the core's inputs. The
  // core updates its PC on the commit edge, so taking instr_addr live in
  // FETCH sees the new PC; the core holds every input stable while stalled.
  // Because the state register resets asynchronously, a reset during a
  // request drops bus_req immediately.
  assign w_in_fetch    = (r_state == ST_FETCH);
  assign w_in_data     = (r_state == ST_DATA);
  assign w_in_access   = w_in_fetch || w_in_data;
  assign w_access_addr = w_in_fetch ? instr_addr : data_addr;
  assign w_misaligned  = is_misaligned(w_access_addr);
  assign w_req         = w_in_access && !w_misaligned;
  // A store wins over a simultaneous load flag.
  assign w_is_store    = should_write_mem;

  assign bus_req   = w_req;
  assign bus_we    = w_in_data && w_is_store;
  assign bus_addr  = w_in_access ? w_access_addr : 32'd0;
  assign bus_wdata = (w_in_data && w_is_store) ? mem_write_data : 32'd0;

  // The counter is held clear whenever no request is outstanding, which is
  // always true for at least one cycle before FETCH or DATA is entered.
  bus_timeout_counter #(
    .WIDTH (c_TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_req),
    .enable  (w_req && !bus_ack),
    .limit   (c_TIMEOUT_LIMIT),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_instr          <= NOP_INSTR;
      r_mem_read_data  <= 32'd0;
      r_core_stall     <= 1'b1;
      r_fault_timeout  <= 1'b0;
      r_fault_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
        end

        ST_FETCH: begin
          // Misalignment takes priority: no request was issued, so any ack
          // seen now belongs to someone else.
          if (w_misaligned) begin
            r_instr          <= NOP_INSTR;
            r_fault_misalign <= 1'b1;
            r_state          <= ST_DECODE;
          end else if (bus_ack) begin
            r_instr <= bus_rdata;
            r_state <= ST_DECODE;
          end else if (w_expired) begin
            r_instr         <= NOP_INSTR;
            r_fault_timeout <= 1'b1;
            r_state         <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (should_read_mem || should_write_mem) begin
            r_state <= ST_DATA;
          end else begin
            r_state      <= ST_COMMIT;
            r_core_stall <= 1'b0;
          end
        end

        ST_DATA: begin
          if (w_misaligned) begin
            r_fault_misalign <= 1'b1;
            if (!w_is_store) r_mem_read_data <= 32'd0;
            r_state      <= ST_COMMIT;
            r_core_stall <= 1'b0;
          end else if (bus_ack) begin
            if (!w_is_store) r_mem_read_data <= bus_rdata;
            r_state      <= ST_COMMIT;
            r_core_stall <= 1'b0;
          end else if (w_expired) begin
            r_fault_timeout <= 1'b1;
            if (!w_is_store) r_mem_read_data <= 32'd0;
            r_state      <= ST_COMMIT;
            r_core_stall <= 1'b0;
          end
        end

        ST_COMMIT: begin
          r_core_stall <= 1'b1;
          r_state      <= ST_FETCH;
        end

        default: begin
          r_core_stall <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr          = r_instr;
  assign mem_read_data  = r_mem_read_data;
  assign core_stall     = r_core_stall;
  assign fault_timeout  = r_fault_timeout;
  assign fault_misalign = r_fault_misalign;

endmodule
`default_nettype wire
